pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register that generalises the fixed decode/execute latch bank into a reusable stage for any pipeline boundary. It carries a control field (zeroed on bubbles) and a data payload through a valid/ready handshake, and supports stall back-pressure, synchronous flush and an optional one-entry skid buffer. It also keeps a saturating stall-cycle counter for performance debug. It sits between any two stages (fetch/decode, decode/execute, execute/memory, memory/writeback).

---
 rtl/pipe_stage_reg_pkg.sv | 18 +
 rtl/pipe_hold_reg.sv | 21 ++
 rtl/pipe_stage_reg.sv | 155 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared defaults, skid-FSM state encoding and bubble control value for pipe_stage_reg.
package pipe_stage_reg_pkg;

  localparam int CTRL_W_DEF = 16;
  localparam int DATA_W_DEF = 64;
  localparam int CNT_W_DEF  = 16;
  localparam int SKID_DEF   = 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_st_e;

  // A bubble carries an all-zero control field.
  localparam logic BUBBLE_BIT = 1'b0;

endpackage

// File: rtl/pipe_hold_reg.sv
// Register slot with load enable and synchronous active-low clear; 1-cycle latency.
// No flow control of its own: the owning stage decides when to load or clear.
module pipe_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage with flush, optional one-entry skid and stall counter; 1-cycle latency.
// Backpressure: ready_out is registered (EMPTY/FULL=1, SKID=0) when SKID=1, else ready_in | ~valid_out.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SKID   = SKID_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  stage_st_e         state_q, state_d;
  logic              acc, del;
  logic              main_ld, main_from_skid, main_clr, skid_ld;
  logic [CTRL_W-1:0] main_ctrl_d, skid_ctrl;
  logic [DATA_W-1:0] main_data_d, skid_data;

  assign valid_out = (state_q != ST_EMPTY);
  assign acc       = valid_in & ready_out;
  assign del       = valid_out & ready_in;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Without a skid slot, FULL never sees accept-without-deliver because ready_out drops.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    main_clr       = 1'b0;
    skid_ld        = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            main_ld = 1'b1;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (acc && del) begin
            main_ld = 1'b1;
          end else if (acc) begin
            skid_ld = 1'b1;
            state_d = ST_SKID;
          end else if (del) begin
            main_clr = 1'b1;
            state_d  = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (del) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ST_FULL;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          main_clr = 1'b1;
        end
      endcase
    end
  end

  assign main_ctrl_d = main_from_skid ? skid_ctrl : ctrl_in;
  assign main_data_d = main_from_skid ? skid_data : data_in;

  // Control is zeroed on every return to a bubble; the payload only clears on reset.
  pipe_hold_reg #(.W(CTRL_W)) u_main_ctrl (
    .clk   (clk),
    .clr_n (rst & ~main_clr),
    .ld    (main_ld),
    .d     (main_ctrl_d),
    .q     (ctrl_out)
  );

  pipe_hold_reg #(.W(DATA_W)) u_main_data (
    .clk   (clk),
    .clr_n (rst),
    .ld    (main_ld),
    .d     (main_data_d),
    .q     (data_out)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic rdy_q;

      pipe_hold_reg #(.W(CTRL_W)) u_skid_ctrl (
        .clk   (clk),
        .clr_n (rst & ~flush),
        .ld    (skid_ld),
        .d     (ctrl_in),
        .q     (skid_ctrl)
      );

      pipe_hold_reg #(.W(DATA_W)) u_skid_data (
        .clk   (clk),
        .clr_n (rst & ~flush),
        .ld    (skid_ld),
        .d     (data_in),
        .q     (skid_data)
      );

      always_ff @(posedge clk) begin
        if (!rst) begin
          rdy_q <= 1'b1;
        end else begin
          rdy_q <= (state_d != ST_SKID);
        end
      end

      // Reset gating keeps ready low while held in reset and high right after release.
      assign ready_out = rst & rdy_q;
    end else begin : g_noskid
      assign skid_ctrl = {CTRL_W{BUBBLE_BIT}};
      assign skid_data = '0;
      assign ready_out = rst & (ready_in | ~valid_out);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (valid_out && !ready_in && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Lane 0 runs SKID=0, lane 1 runs SKID=1; both are checked every cycle against a
// FIFO-occupancy reference model, with directed scenarios followed by random traffic.
module tb_pipe_stage_reg;

  localparam int CW = 4;
  localparam int DW = 16;
  localparam int NW = 4;
  localparam int CNT_MAX = (1 << NW) - 1;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic rst, rin, fl, sc;
  logic          vin  [2];
  logic [CW-1:0] cin  [2];
  logic [DW-1:0] din  [2];
  logic          vout [2];
  logic          rout [2];
  logic [CW-1:0] cout [2];
  logic [DW-1:0] dout [2];
  logic [NW-1:0] cnt  [2];

  beat_t         mq [2][$];
  logic [DW-1:0] last_d [2];
  int            mcnt [2];
  bit            taken [2];
  logic [DW-1:0] ns [2];
  logic [DW-1:0] sexp [3];
  bit            armed, rnd_data;
  int            checks, errors;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(g), .CNT_W(NW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (vin[g]),
      .ready_out (rout[g]),
      .ctrl_in   (cin[g]),
      .data_in   (din[g]),
      .valid_out (vout[g]),
      .ready_in  (rin),
      .ctrl_out  (cout[g]),
      .data_out  (dout[g]),
      .flush     (fl),
      .stall_cnt (cnt[g]),
      .stall_clr (sc)
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Lane 0 holds one beat and passes ready through; lane 1 holds two and reports registered occupancy.
  function automatic bit exp_rdy(input int g);
    if (!rst) return 1'b0;
    if (g == 1) return mq[g].size() < 2;
    return (mq[g].size() == 0) || rin;
  endfunction

  task automatic check_model();
    bit busy;
    for (int g = 0; g < 2; g++) begin
      busy = mq[g].size() > 0;
      chk($sformatf("L%0d_valid", g), 64'(vout[g]), 64'(busy));
      chk($sformatf("L%0d_ctrl", g), 64'(cout[g]), 64'(busy ? mq[g][0].c : 4'h0));
      chk($sformatf("L%0d_data", g), 64'(dout[g]), 64'(busy ? mq[g][0].d : last_d[g]));
      chk($sformatf("L%0d_ready", g), 64'(rout[g]), 64'(exp_rdy(g)));
      chk($sformatf("L%0d_cnt", g), 64'(cnt[g]), 64'(mcnt[g]));
    end
  endtask

  task automatic model_update();
    bit acc, del, stall;
    for (int g = 0; g < 2; g++) begin
      if (!rst) begin
        mq[g].delete();
        last_d[g] = '0;
        mcnt[g]   = 0;
        taken[g]  = 1'b0;
        armed     = 1'b1;
      end else begin
        acc   = vin[g] && exp_rdy(g);
        del   = (mq[g].size() > 0) && rin;
        stall = (mq[g].size() > 0) && !rin;
        if (sc) mcnt[g] = 0;
        else if (stall && mcnt[g] < CNT_MAX) mcnt[g] = mcnt[g] + 1;
        if (mq[g].size() > 0) last_d[g] = mq[g][0].d;
        if (fl) begin
          mq[g].delete();
        end else begin
          if (del) void'(mq[g].pop_front());
          if (acc) mq[g].push_back({cin[g], din[g]});
        end
        taken[g] = acc || fl;
      end
    end
  endtask

  // Drive one cycle of stimulus; an unaccepted beat is held until taken or flushed.
  task automatic cycle(input bit v, input bit r, input bit f, input bit c);
    for (int g = 0; g < 2; g++) begin
      if (v && !(vin[g] && !taken[g])) begin
        din[g] = rnd_data ? DW'($urandom) : ns[g];
        if (!rnd_data) ns[g] = ns[g] + 16'h1111;
        cin[g] = CW'($urandom_range(1, (1 << CW) - 1));
      end
      vin[g] = v;
    end
    rin = r;
    fl  = f;
    sc  = c;
    #3;
    if (armed) check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; armed = 1'b0; rnd_data = 1'b0;
    rst = 1'b0; rin = 1'b0; fl = 1'b0; sc = 1'b0;
    sexp[0] = 16'h1111; sexp[1] = 16'h2222; sexp[2] = 16'h3333;
    for (int g = 0; g < 2; g++) begin
      vin[g] = 1'b0; cin[g] = '0; din[g] = '0; taken[g] = 1'b0;
      ns[g] = 16'h1111; last_d[g] = '0; mcnt[g] = 0;
    end

    repeat (3) cycle(0, 0, 0, 0);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("L%0d_rst_valid", g), 64'(vout[g]), 64'(0));
      chk($sformatf("L%0d_rst_ctrl", g), 64'(cout[g]), 64'(0));
      chk($sformatf("L%0d_rst_data", g), 64'(dout[g]), 64'(0));
      chk($sformatf("L%0d_rst_cnt", g), 64'(cnt[g]), 64'(0));
      chk($sformatf("L%0d_rst_ready", g), 64'(rout[g]), 64'(0));
    end
    rst = 1'b1;
    cycle(0, 1, 0, 0);

    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 0, 0);
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("L%0d_stream%0d", g, i), 64'(dout[g]), 64'(sexp[i]));
      end
    end
    repeat (3) cycle(0, 1, 0, 0);

    cycle(1, 1, 0, 1);
    repeat (3) cycle(1, 0, 0, 0);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("L%0d_bp_cnt", g), 64'(cnt[g]), 64'(3));
      chk($sformatf("L%0d_bp_ready", g), 64'(rout[g]), 64'(0));
    end
    repeat (5) cycle(0, 1, 0, 0);

    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 0);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("L%0d_fl_valid", g), 64'(vout[g]), 64'(0));
      chk($sformatf("L%0d_fl_ctrl", g), 64'(cout[g]), 64'(0));
      chk($sformatf("L%0d_fl_ready", g), 64'(rout[g]), 64'(1));
      ns[g] = 16'hABCD;
    end
    cycle(1, 1, 0, 0);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("L%0d_abcd_valid", g), 64'(vout[g]), 64'(1));
      chk($sformatf("L%0d_abcd_data", g), 64'(dout[g]), 64'(16'hABCD));
    end
    repeat (2) cycle(0, 1, 0, 0);

    cycle(1, 1, 0, 1);
    repeat (20) cycle(0, 0, 0, 0);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("L%0d_sat", g), 64'(cnt[g]), 64'(15));
    end
    cycle(0, 0, 0, 1);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("L%0d_clr", g), 64'(cnt[g]), 64'(0));
    end

    cycle(1, 0, 0, 0);
    rst = 1'b0;
    cycle(0, 0, 0, 0);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("L%0d_mid_valid", g), 64'(vout[g]), 64'(0));
      chk($sformatf("L%0d_mid_ctrl", g), 64'(cout[g]), 64'(0));
      chk($sformatf("L%0d_mid_data", g), 64'(dout[g]), 64'(0));
      chk($sformatf("L%0d_mid_cnt", g), 64'(cnt[g]), 64'(0));
      chk($sformatf("L%0d_mid_ready", g), 64'(rout[g]), 64'(0));
    end
    rst = 1'b1;
    cycle(1, 1, 0, 0);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("L%0d_rel_valid", g), 64'(vout[g]), 64'(1));
      chk($sformatf("L%0d_rel_data", g), 64'(dout[g]), 64'(din[g]));
    end
    repeat (2) cycle(0, 1, 0, 0);

    rnd_data = 1'b1;
    repeat (3000) begin
      rst = ($urandom_range(0, 399) != 0);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 49) == 0);
    end
    rst = 1'b1;
    repeat (4) cycle(0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
